// File: rtl/seg_scan_if.sv
// Bus between the display sequencer and its host: value/load request in,
// status flags and the multiplexed anode/cathode drive out.
interface seg_scan_if #(
  parameter int VAL_W = 14
);
  logic [VAL_W-1:0] value_in;
  logic             load;
  logic             busy;
  logic             done;
  logic             ovf;
  logic [3:0]       anode;
  logic [6:0]       cathode;
  logic [1:0]       state_dbg;

  // Handshake: load is a one-cycle request taken only while busy=0; the
  // sequencer answers with a one-cycle done pulse when the new digits commit.
  modport master (
    output value_in, load,
    input  busy, done, ovf, anode, cathode, state_dbg
  );

  modport slave (
    input  value_in, load,
    output busy, done, ovf, anode, cathode, state_dbg
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Binary-to-BCD (shift-add-3) sequencer and four-digit seven-segment scanner.
// Optional macro SEG_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module seg_scan_ctrl #(
  parameter int CLK_DIV = 100000,
  parameter int VAL_W   = 14
) (
  input logic       clk,
  input logic       rst,
  seg_scan_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam int               SW         = VAL_W + 16;
  localparam logic [VAL_W-1:0] MAX_VAL    = VAL_W'(9999);
  localparam logic [20:0]      PRESC_LAST = 21'(CLK_DIV - 1);

  state_t           state_q;
  logic [SW-1:0]    sh_q;
  logic [SW-1:0]    sh_adj;
  logic [SW-1:0]    sh_d;
  logic [3:0]       iter_q;
  logic             busy_q;
  logic             done_q;
  logic             ovf_q;
  logic [15:0]      digits_q;
  logic [VAL_W-1:0] clamped;

  logic [20:0]      presc_q;
  logic [1:0]       idx_q;
  logic [3:0]       anode_q;
  logic [6:0]       cathode_q;
  logic [3:0]       slot_digit;
  logic             slot_blank;

  assign clamped = (bus.value_in > MAX_VAL) ? MAX_VAL : bus.value_in;

  // One double-dabble step: correct every BCD nibble >= 5, then shift.
  always_comb begin
    sh_adj = sh_q;
    for (int i = 0; i < 4; i++) begin
      if (sh_q[VAL_W + 4*i +: 4] >= 4'd5)
        sh_adj[VAL_W + 4*i +: 4] = sh_q[VAL_W + 4*i +: 4] + 4'd3;
    end
    sh_d = sh_adj << 1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sh_q     <= '0;
      iter_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      digits_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.load) begin
            sh_q    <= {16'd0, clamped};
            ovf_q   <= (bus.value_in > MAX_VAL);
            iter_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          sh_q   <= sh_d;
          iter_q <= iter_q + 4'd1;
          if (iter_q == 4'(VAL_W - 1)) state_q <= COMMIT;
        end
        COMMIT: begin
          digits_q <= sh_q[VAL_W +: 16];
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic [3:0] blank_q;

  // Ones digit is never blanked; higher slots blank while everything above is zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blank_q <= '0;
    end else if (state_q == COMMIT) begin
      blank_q <= {sh_q[VAL_W+12 +: 4] == 4'd0,
                  sh_q[VAL_W+8  +: 8] == 8'd0,
                  sh_q[VAL_W+4  +: 12] == 12'd0,
                  1'b0};
    end
  end

  assign slot_blank = blank_q[idx_q];
`else
  assign slot_blank = 1'b0;
`endif

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b0000001;
    endcase
    return s;
  endfunction

  assign slot_digit = digits_q[4*idx_q +: 4];

  // Scan reads only committed digits, so a running conversion never shows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q   <= '0;
      idx_q     <= '0;
      anode_q   <= 4'b1111;
      cathode_q <= 7'b1111111;
    end else begin
      if (presc_q == PRESC_LAST) begin
        presc_q <= '0;
        idx_q   <= idx_q + 2'd1;
      end else begin
        presc_q <= presc_q + 21'd1;
      end
      anode_q   <= ~(4'b0001 << idx_q);
      cathode_q <= slot_blank ? 7'b1111111 : seg_decode(slot_digit);
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.ovf       = ovf_q;
  assign bus.anode     = anode_q;
  assign bus.cathode   = cathode_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: directed loads push expected BCD digits,
// a negedge monitor checks done/ovf and the scanned display every cycle.
module tb_seg_scan_ctrl;

  localparam int CLK_DIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg_scan_if #(.VAL_W(14)) bus ();

  seg_scan_ctrl #(.CLK_DIV(CLK_DIV), .VAL_W(14)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // {ovf, thousands, hundreds, tens, ones}
  logic [16:0] exp_q[$];
  logic [15:0] cur_dig   = '0;
  logic [3:0]  cur_blank = '0;
  bit          scan_ok   = 1'b0;
  int          busy_cnt  = 0;
  int          done_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'b0000001;
      4'd1: return 7'b1001111;
      4'd2: return 7'b0010010;
      4'd3: return 7'b0000110;
      4'd4: return 7'b1001100;
      4'd5: return 7'b0100100;
      4'd6: return 7'b0100000;
      4'd7: return 7'b0001111;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0000100;
      default: return 7'b0000001;
    endcase
  endfunction

  function automatic logic [6:0] exp_cath(input int slot);
`ifdef SEG_LEADING_ZERO_BLANK_EN
    if (cur_blank[slot]) return 7'b1111111;
`endif
    return seg_of(cur_dig[4*slot +: 4]);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) scan_ok <= 1'b0;
    else     scan_ok <= 1'b1;
  end

  // Monitor: display check first (still old digits in the done cycle), then pop on done.
  always @(negedge clk) begin
    int slot;
    logic [16:0] e;
    if (rst) begin
      cur_dig   = '0;
      cur_blank = '0;
      busy_cnt  = 0;
      done_cnt  = 0;
    end else if (scan_ok) begin
      case (bus.anode)
        4'b1110: slot = 0;
        4'b1101: slot = 1;
        4'b1011: slot = 2;
        4'b0111: slot = 3;
        default: slot = -1;
      endcase
      if (slot < 0) check("anode_onehot", {28'd0, bus.anode}, 32'he);
      else          check("cathode_slot", {25'd0, bus.cathode}, {25'd0, exp_cath(slot)});

      if (bus.busy) busy_cnt++;
      else begin
        if (busy_cnt != 0) check("busy_width", busy_cnt, 15);
        busy_cnt = 0;
      end

      if (bus.done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=1 expected=0 at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          check("ovf_at_done", {31'd0, bus.ovf}, {31'd0, e[16]});
          cur_dig   = e[15:0];
          cur_blank = {e[15:12] == 4'd0, e[15:8] == 8'd0, e[15:4] == 12'd0, 1'b0};
        end
      end else begin
        if (done_cnt != 0) check("done_width", done_cnt, 1);
        done_cnt = 0;
      end
    end
  end

  task automatic load_val(input logic [13:0] v, input bit accept, input logic [16:0] e);
    @(negedge clk);
    bus.value_in = v;
    bus.load     = 1'b1;
    if (accept) exp_q.push_back(e);
    @(negedge clk);
    bus.load = 1'b0;
    if (accept) check("busy_after_load", {31'd0, bus.busy}, 32'd1);
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=0 expected=1 at %0t", $time);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [3:0] exp_an;
    bus.value_in = '0;
    bus.load     = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_anode",   {28'd0, bus.anode},   32'hf);
    check("rst_cathode", {25'd0, bus.cathode}, 32'h7f);
    check("rst_busy",    {31'd0, bus.busy},    32'd0);
    check("rst_done",    {31'd0, bus.done},    32'd0);
    check("rst_ovf",     {31'd0, bus.ovf},     32'd0);

    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      exp_an = ~(4'b0001 << ((k / 4) % 4));
      check("scan_seq", {28'd0, bus.anode}, {28'd0, exp_an});
      check("idle_busy", {31'd0, bus.busy}, 32'd0);
    end

    load_val(14'd1234, 1'b1, 17'h0_1234);
    wait_done();
    idle(20);

    load_val(14'd12345, 1'b1, 17'h1_9999);
    wait_done();
    idle(20);
    check("ovf_held", {31'd0, bus.ovf}, 32'd1);

    load_val(14'd5, 1'b1, 17'h0_0005);
    wait_done();
    idle(20);

    // Loads while busy are dropped, including an out-of-range one that must not touch ovf.
    load_val(14'd42, 1'b1, 17'h0_0042);
    idle(2);
    load_val(14'd99, 1'b0, 17'h0);
    idle(1);
    load_val(14'd12345, 1'b0, 17'h0);
    check("ovf_ignored_load", {31'd0, bus.ovf}, 32'd0);
    wait_done();
    bus.value_in = 14'd99;
    bus.load     = 1'b1;
    exp_q.push_back(17'h0_0099);
    @(negedge clk);
    bus.load = 1'b0;
    check("busy_load_in_done", {31'd0, bus.busy}, 32'd1);
    wait_done();
    idle(20);

    // Reset in the middle of a conversion.
    load_val(14'd8000, 1'b0, 17'h0);
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_anode",   {28'd0, bus.anode},   32'hf);
    check("abort_cathode", {25'd0, bus.cathode}, 32'h7f);
    check("abort_busy",    {31'd0, bus.busy},    32'd0);
    idle(2);
    rst = 1'b0;
    idle(40);
    check("abort_ovf", {31'd0, bus.ovf}, 32'd0);

    load_val(14'd0, 1'b1, 17'h0_0000);
    wait_done();
    idle(20);
    load_val(14'd100, 1'b1, 17'h0_0100);
    wait_done();
    idle(20);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Sequencer for the four-digit seven-segment display path.
- Accepts a binary value on a load strobe and converts it to four BCD digits sequentially with shift-add-3, 14 iterations; no dividers.
- Commits the four digits atomically, then time-multiplexes them onto one shared cathode bus with active-low anode select.
- Sits between the ALSU result and the board display pins.

Parameters:
- CLK_DIV, 100000, clock cycles per digit slot (refresh prescaler); legal range 1..2^20.
- VAL_W, 14, width of value_in; fixed requirement VAL_W = 14 (range 0..16383).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- value_in  in  14  binary value to display.
- load  in  1  one-cycle request; accepted only when busy=0.
- busy  out  1  conversion in progress.
- done  out  1  one-cycle pulse when new digits are committed.
- ovf  out  1  last accepted value exceeded 9999; held until next accepted load.
- anode  out  4  active-low digit enable; bit0 = ones ... bit3 = thousands.
- cathode  out  7  active-low segments {a,b,c,d,e,f,g}.

Behaviour:
- Reset (async, immediate): anode=4'b1111, cathode=7'b1111111, busy=0, done=0, ovf=0, digit regs=0, scan index=0, prescaler=0, FSM=IDLE.
- FSM states and transitions:
  - IDLE: load=1 at an edge -> SHIFT; shift reg <= min(value_in, 9999); ovf <= (value_in > 9999); iteration count=0; busy=1.
  - SHIFT: one iteration per cycle (add 3 to each BCD nibble >= 5, then shift left 1). After the 14th iteration -> COMMIT.
  - COMMIT: all four digit regs written in the same edge; busy=0; done=1 for exactly one cycle; -> IDLE.
- Latency: load sampled at edge N -> busy=1 after N -> digits committed and done=1 after edge N+15 -> cathode shows new digit at edge N+16. busy is high for exactly 15 cycles.
- load while busy=1 is ignored: no queueing, ovf unchanged.
- load in the same cycle that done=1 is accepted, because busy is already 0.
- Display never shows partially converted digits; scan reads only committed regs.
- Prescaler:
  - Counts 0..CLK_DIV-1.
  - At terminal count it wraps to 0 and scan index advances 0->1->2->3->0.
  - With CLK_DIV=1 the index advances every cycle.
  - Scan runs continuously and independently of the FSM.
- Outputs are registered every cycle from the current index:
  - anode = ~(1<<index), exactly one bit low.
  - cathode = decode(digit[index]).
- Decode table, 0..9: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100.
- Digit codes 10..15 are unreachable; if present they decode as "0" (0000001).
- First edge after reset release: anode=1110, cathode=0000001.
- Reset asserted mid-conversion aborts it: digit regs=0, busy=0, no done pulse.

Optional Feature:
- Macro: SEG_LEADING_ZERO_BLANK_EN.
- Defined: any digit position above the most significant nonzero digit is blanked (cathode=7'b1111111, anode still rotates). The ones digit is never blanked, so value 0 shows "0", and 7 shows "   7".
- Blank mask is computed at COMMIT and stored with the digits.
- Undefined: all four digits are always shown, with leading zeros ("0007").

Test Plan:
- Reset release with CLK_DIV=4: anode sequence 1110 x4 cycles, 1101 x4, 1011 x4, 0111 x4, repeat; cathode=0000001 throughout; busy=0.
- load value_in=1234 at edge N: busy high edges N..N+14, done pulse after N+15; slot digits ones=4 (1001100), tens=3 (0000110), hundreds=2 (0010010), thousands=1 (1001111); ovf=0.
- load 12345: displays 9999 (all slots 0000100), ovf=1. Next load 5: ovf=0, display 0005 (or blank-blank-blank-5 with SEG_LEADING_ZERO_BLANK_EN).
- load 42, then load 99 at edge N+5 while busy: 99 ignored, display shows 0042. load 99 in the done cycle: accepted, display 0099 after 16 more edges.
- Assert rst at edge N+7 during conversion of 8000: anode=1111 and cathode=1111111 immediately; after release display 0000, no done pulse.
- SEG_LEADING_ZERO_BLANK_EN defined, load 0 then 100: "   0" then " 100"; the thousands slot cathode is 1111111 while its anode bit is low.
